// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and address helpers for the Kyber forward-NTT sequencer.
// The helpers map (layer, butterfly index) to the coefficient pair and the zeta ROM index.
package ntt_pkg;

    localparam int unsigned N            = 256;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned ZETA_AW      = 7;
    localparam int unsigned LAYERS       = 7;
    localparam int unsigned LAYER_W      = 3;
    localparam int unsigned BFLY_W       = 7;
    localparam int unsigned DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Address of j for butterfly b of layer l; len = 128 >> l.
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [LAYER_W-1:0] l,
                                                    input logic [BFLY_W-1:0]  b);
        logic [ADDR_W-1:0] len;
        logic [ADDR_W-1:0] grp;
        logic [ADDR_W-1:0] off;
        len = ADDR_W'(N / 2) >> l;
        grp = {1'b0, b} >> (LAYER_W'(LAYERS) - l);
        off = {1'b0, b} & (len - ADDR_W'(1));
        return (grp << (4'(ADDR_W) - {1'b0, l})) | off;
    endfunction

    function automatic logic [ZETA_AW-1:0] zeta_idx(input logic [LAYER_W-1:0] l,
                                                    input logic [BFLY_W-1:0]  b);
        return (ZETA_AW'(1) << l) + ZETA_AW'(b >> (LAYER_W'(LAYERS) - l));
    endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational read-address generator: (layer, butterfly) -> pair addresses and zeta index.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [LAYER_W-1:0] layer_i,
    input  logic [BFLY_W-1:0]  bfly_i,
    output logic [ADDR_W-1:0]  addr_a_o,
    output logic [ADDR_W-1:0]  addr_b_o,
    output logic [ZETA_AW-1:0] zeta_addr_o
);

    always_comb begin
        addr_a_o    = pair_addr(layer_i, bfly_i);
        addr_b_o    = addr_a_o + (ADDR_W'(N / 2) >> layer_i);
        zeta_addr_o = zeta_idx(layer_i, bfly_i);
    end

endmodule

// File: rtl/ntt_layer_ctrl.sv
// Forward Kyber NTT sequencer: walks 7 layers, one butterfly per cycle, writes results in place
// two cycles after each read through an external combinational butterfly.
module ntt_layer_ctrl
    import ntt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr_a,
    output logic [ADDR_W-1:0]   rd_addr_b,
    input  logic [DATA_W-1:0]   rd_data_a,
    input  logic [DATA_W-1:0]   rd_data_b,
    output logic [ZETA_AW-1:0]  zeta_addr,
    input  logic [DATA_W-1:0]   zeta_data,
    output logic [DATA_W-1:0]   bf_u,
    output logic [DATA_W-1:0]   bf_v,
    output logic [DATA_W-1:0]   bf_zeta,
    input  logic [DATA_W-1:0]   bf_upper,
    input  logic [DATA_W-1:0]   bf_lower,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr_a,
    output logic [ADDR_W-1:0]   wr_addr_b,
    output logic [DATA_W-1:0]   wr_data_a,
    output logic [DATA_W-1:0]   wr_data_b
);

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [BFLY_W-1:0]  bfly_q, bfly_d;
    logic [1:0]         drain_q, drain_d;

    logic [ADDR_W-1:0]  gen_addr_a, gen_addr_b;
    logic [ZETA_AW-1:0] gen_zeta;

    logic               s1_valid_q;
    logic [ADDR_W-1:0]  s1_addr_a_q, s1_addr_b_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_a_q, wr_addr_b_q;
    logic [DATA_W-1:0]  wr_data_a_q, wr_data_b_q;

    ntt_addr_gen u_addr_gen (
        .layer_i     (layer_q),
        .bfly_i      (bfly_q),
        .addr_a_o    (gen_addr_a),
        .addr_b_o    (gen_addr_b),
        .zeta_addr_o (gen_zeta)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            layer_q <= '0;
            bfly_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            bfly_q  <= bfly_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        bfly_d  = bfly_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    layer_d = '0;
                    bfly_d  = '0;
                end
            end
            StRun: begin
                if (bfly_q == '1) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    bfly_d = bfly_q + BFLY_W'(1);
                end
            end
            StDrain: begin
                // Hold off reads until the layer's last write has landed.
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    if (layer_q == LAYER_W'(LAYERS - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        layer_d = layer_q + LAYER_W'(1);
                        bfly_d  = '0;
                    end
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en     = (state_q == StRun);
        busy      = (state_q == StRun) || (state_q == StDrain);
        done      = (state_q == StDone);
        rd_addr_a = rd_en ? gen_addr_a : '0;
        rd_addr_b = rd_en ? gen_addr_b : '0;
        zeta_addr = rd_en ? gen_zeta : '0;
        bf_u      = rd_data_a;
        bf_v      = rd_data_b;
        bf_zeta   = zeta_data;
    end

    // Stage 1 carries the read addresses alongside the data; stage 2 drives the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_addr_a_q <= '0;
            s1_addr_b_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            wr_data_a_q <= '0;
            wr_data_b_q <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_addr_a_q <= rd_addr_a;
                s1_addr_b_q <= rd_addr_b;
            end
            wr_en_q <= s1_valid_q;
            if (s1_valid_q) begin
                wr_addr_a_q <= s1_addr_a_q;
                wr_addr_b_q <= s1_addr_b_q;
                wr_data_a_q <= bf_upper;
                wr_data_b_q <= bf_lower;
            end
        end
    end

    always_comb begin
        wr_en     = wr_en_q;
        wr_addr_a = wr_addr_a_q;
        wr_addr_b = wr_addr_b_q;
        wr_data_a = wr_data_a_q;
        wr_data_b = wr_data_b_q;
    end

endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// Bench for ntt_layer_ctrl: RAM/ROM model, Montgomery butterfly and a software Kyber NTT reference.
module tb_ntt_layer_ctrl;

    typedef logic signed [15:0] arr_t [256];

    typedef struct {
        int cyc;
        bit chk_rd;
        bit rd;
        int ra;
        int rb;
        int z;
        bit chk_wr;
        bit wr;
        int wa;
        int wb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, rd_en, wr_en;
    logic [7:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0]  zeta_addr;
    logic [15:0] rd_data_a, rd_data_b, zeta_data;
    logic [15:0] bf_u, bf_v, bf_zeta, bf_upper, bf_lower, wr_data_a, wr_data_b;

    logic signed [15:0] ram [256];
    logic signed [15:0] zrom [128];
    arr_t img;
    logic load = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    ntt_layer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .zeta_addr (zeta_addr),
        .zeta_data (zeta_data),
        .bf_u      (bf_u),
        .bf_v      (bf_v),
        .bf_zeta   (bf_zeta),
        .bf_upper  (bf_upper),
        .bf_lower  (bf_lower),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .wr_data_a (wr_data_a),
        .wr_data_b (wr_data_b)
    );

    function automatic logic signed [15:0] mred(input int a);
        int p;
        logic signed [15:0] t;
        p = a * -3327;
        t = p[15:0];
        return 16'((a - int'(t) * 3329) >>> 16);
    endfunction

    function automatic logic signed [15:0] fqmul(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
        return mred(int'(a) * int'(b));
    endfunction

    always_comb begin
        logic signed [15:0] t;
        t = fqmul(bf_zeta, bf_v);
        bf_upper = bf_u + t;
        bf_lower = bf_u - t;
    end

    always @(posedge clk) begin
        if (load) begin
            ram <= img;
        end else begin
            if (rd_en) begin
                rd_data_a <= ram[rd_addr_a];
                rd_data_b <= ram[rd_addr_b];
                zeta_data <= zrom[zeta_addr];
            end
            if (wr_en) begin
                ram[wr_addr_a] <= wr_data_a;
                ram[wr_addr_b] <= wr_data_b;
            end
        end
    end

    function automatic arr_t ntt_model(input arr_t a);
        arr_t r;
        int k;
        logic signed [15:0] t;
        r = a;
        k = 1;
        for (int len = 128; len >= 2; len = len >> 1) begin
            for (int s = 0; s < 256; s = s + 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    t = fqmul(zrom[k], r[j + len]);
                    r[j + len] = r[j] - t;
                    r[j] = r[j] + t;
                end
                k++;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_img();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic check_ram(input string name, input arr_t exp);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp[i]) nbad++;
        check({name, " mismatching words"}, nbad, 0);
        check({name, " r[1]"}, int'(ram[1]), int'(exp[1]));
    endtask

    task automatic run(input bit chk_vec, input bit extra, input int abort_at);
        int done_cnt, done_cyc, busy_bad;
        done_cnt = 0;
        done_cyc = -1;
        busy_bad = 0;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 912; c++) begin
            @(negedge clk);
            start = extra && (c == 50 || c == 500);
            if (c == abort_at) begin
                rst = 1'b1;
                #1 check("abort wr_en same cycle", int'(wr_en), 0);
                @(negedge clk);
                check("abort wr_en next cycle", int'(wr_en), 0);
                check("abort busy", int'(busy), 0);
                rst = 1'b0;
                return;
            end
            if (busy !== (c <= 910)) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (chk_vec) begin
                for (int i = 0; i < 14; i++) begin
                    if (vecs[i].cyc == c) begin
                        if (vecs[i].chk_rd) begin
                            check($sformatf("c%0d rd_en", c), int'(rd_en), int'(vecs[i].rd));
                            if (vecs[i].rd) begin
                                check($sformatf("c%0d rd_addr_a", c), int'(rd_addr_a), vecs[i].ra);
                                check($sformatf("c%0d rd_addr_b", c), int'(rd_addr_b), vecs[i].rb);
                                check($sformatf("c%0d zeta_addr", c), int'(zeta_addr), vecs[i].z);
                            end
                        end
                        if (vecs[i].chk_wr) begin
                            check($sformatf("c%0d wr_en", c), int'(wr_en), int'(vecs[i].wr));
                            if (vecs[i].wr) begin
                                check($sformatf("c%0d wr_addr_a", c), int'(wr_addr_a), vecs[i].wa);
                                check($sformatf("c%0d wr_addr_b", c), int'(wr_addr_b), vecs[i].wb);
                            end
                        end
                    end
                end
            end
        end
        check("done pulse count", done_cnt, 1);
        check("done cycle", done_cyc, 911);
        check("busy window errors", busy_bad, 0);
    endtask

    initial begin
        arr_t exp_r, snap;
        int p, br, z;

        for (int k = 0; k < 128; k++) begin
            br = 0;
            for (int i = 0; i < 7; i++) if (k[i]) br = br | (1 << (6 - i));
            p = 1;
            for (int i = 0; i < br; i++) p = (p * 17) % 3329;
            z = (2285 * p) % 3329;
            if (z > 1664) z = z - 3329;
            zrom[k] = 16'(z);
        end

        vecs[0]  = '{1,   1, 1, 0,   128, 1,   1, 0, 0,   0};
        vecs[1]  = '{2,   1, 1, 1,   129, 1,   1, 0, 0,   0};
        vecs[2]  = '{3,   1, 1, 2,   130, 1,   1, 1, 0,   128};
        vecs[3]  = '{128, 1, 1, 127, 255, 1,   1, 1, 125, 253};
        vecs[4]  = '{129, 1, 0, 0,   0,   0,   1, 1, 126, 254};
        vecs[5]  = '{130, 1, 0, 0,   0,   0,   1, 1, 127, 255};
        vecs[6]  = '{131, 1, 1, 0,   64,  2,   1, 0, 0,   0};
        vecs[7]  = '{195, 1, 1, 128, 192, 3,   0, 0, 0,   0};
        vecs[8]  = '{781, 1, 1, 0,   2,   64,  1, 0, 0,   0};
        vecs[9]  = '{782, 1, 1, 1,   3,   64,  0, 0, 0,   0};
        vecs[10] = '{783, 1, 1, 4,   6,   65,  0, 0, 0,   0};
        vecs[11] = '{908, 1, 1, 253, 255, 127, 0, 0, 0,   0};
        vecs[12] = '{910, 1, 0, 0,   0,   0,   1, 1, 253, 255};
        vecs[13] = '{911, 1, 0, 0,   0,   0,   1, 0, 0,   0};

        for (int i = 0; i < 256; i++) img[i] = '0;
        img[0] = 16'sd1;
        load_img();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle outputs", int'(|{busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b,
                                        zeta_addr, wr_addr_a, wr_addr_b, wr_data_a,
                                        wr_data_b}), 0);
        end

        run(1'b1, 1'b0, 0);
        exp_r = ntt_model(img);
        check_ram("delta ntt", exp_r);

        for (int i = 0; i < 256; i++) img[i] = 16'($urandom_range(0, 6658)) - 16'sd3329;
        load_img();
        run(1'b0, 1'b1, 0);
        exp_r = ntt_model(img);
        check_ram("random ntt", exp_r);

        load_img();
        run(1'b0, 1'b0, 300);
        @(posedge clk);
        #1 snap = ram;
        repeat (2) @(negedge clk);
        run(1'b0, 1'b0, 0);
        exp_r = ntt_model(snap);
        check_ram("post-abort ntt", exp_r);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_layer_ctrl.md
Name: ntt_layer_ctrl

Overview:
Sequencer for the forward Kyber NTT, built around the combinational Montgomery butterfly (inputs u, v, zeta; outputs out_upper, out_lower).
- Walks all 7 Cooley-Tukey layers over a 256-coefficient dual-port RAM.
- Reads coefficient pairs and zetas and presents them to the butterfly.
- Registers the butterfly results and writes them back in place.
- The butterfly is external and connects through the bf_* ports.

Parameters:
DATA_W, 16, coefficient and zeta width (signed).
ADDR_W, 8, coefficient RAM address width (256 entries).
ZETA_AW, 7, zeta ROM address width (128 entries).
LAYERS, 7, number of NTT layers (len = 128 down to 2).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  single-cycle request to begin a full NTT.
busy  out  1  high from the first rd_en cycle through the last wr_en cycle.
done  out  1  one-cycle pulse after the final write.
rd_en  out  1  RAM/ROM read strobe.
rd_addr_a  out  ADDR_W  address of j.
rd_addr_b  out  ADDR_W  address of j+len.
rd_data_a  in  DATA_W  r[j], valid one cycle after rd_en.
rd_data_b  in  DATA_W  r[j+len], valid one cycle after rd_en.
zeta_addr  out  ZETA_AW  zeta ROM index k.
zeta_data  in  DATA_W  zetas[k], valid one cycle after rd_en.
bf_u  out  DATA_W  rd_data_a, passed through combinationally.
bf_v  out  DATA_W  rd_data_b, passed through combinationally.
bf_zeta  out  DATA_W  zeta_data, passed through combinationally.
bf_upper  in  DATA_W  butterfly out_upper.
bf_lower  in  DATA_W  butterfly out_lower.
wr_en  out  1  write strobe for both ports.
wr_addr_a  out  ADDR_W  write address for bf_upper.
wr_addr_b  out  ADDR_W  write address for bf_lower.
wr_data_a  out  DATA_W  registered bf_upper.
wr_data_b  out  DATA_W  registered bf_lower.

Behaviour:
Reset values:
- All registered outputs are 0 (busy, done, rd_en, wr_en, all addresses and data).
- State returns to IDLE; layer and butterfly counters clear.

States:
- IDLE: start=1 moves to RUN.
- RUN: issues one butterfly per cycle. Counter b runs 0..127 within layer l.
  - len = 128>>l; group = b>>(7-l); offset = b & (len-1).
  - rd_addr_a = group*2*len + offset; rd_addr_b = rd_addr_a + len; zeta_addr = (1<<l) + group.
  - After b=127, go to DRAIN.
- DRAIN: exactly 2 cycles with no reads, so the last writes of the layer land before the next layer reads.
  - If l<6: l++, b=0, back to RUN.
  - Else: go to DONE.
- DONE: one cycle; done=1, busy=0; then IDLE.

Pipeline (stage 0 → stage 2 latency = 2 cycles):
- Stage 0: read issued.
- Stage 1: data valid, butterfly evaluates, results and stage-0 addresses are registered.
- Stage 2: wr_en=1 with the registered addresses and data.

Timing:
- start sampled at edge 0 gives the first rd_en in cycle 1.
- Layer l reads occupy cycles 1+130l .. 128+130l.
- Last write is in cycle 910; done is in cycle 911.

Arithmetic and memory rules:
- Controller does no arithmetic on data.
- Address math is unsigned with no wrap: rd_addr_b ≤ 255 by construction.
- RAM returns old data on a read to an address not being written in the same cycle. No same-address read/write collision occurs, by construction.

Boundary conditions:
- start while not IDLE is ignored.
- start in the DONE cycle is ignored.
- Reset mid-operation aborts immediately. The next cycle has no wr_en, and in-flight writes are discarded. The RAM holds a partially transformed array; a new start runs a full 911-cycle sequence.

Decomposition:
Shared package ntt_pkg:
- N=256, DATA_W, ADDR_W, ZETA_AW, LAYERS.
- State enum {IDLE, RUN, DRAIN, DONE}.
- DRAIN_CYCLES=2.
- Functions pair_addr(l,b) and zeta_idx(l,b).

Sub-module ntt_addr_gen: combinational (l,b) → rd_addr_a, rd_addr_b, zeta_addr. Unit-testable separately.

Test Plan:
1. rst=1 then release, start low → all outputs 0, busy=0 for 20 cycles; a rst pulse in any cycle forces wr_en=0 the next cycle.
2. start at edge 0 → cycle 1: rd_addr 0/128, zeta_addr 1. Cycle 128: 127/255, zeta 1. Cycle 3: wr_en, wr_addr 0/128. Cycles 129–130: rd_en=0.
3. Layer-address spot checks:
   - Cycle 195: rd_addr 128/192, zeta 3.
   - Cycle 781: rd_addr 0/2, zeta 64.
   - Cycle 782: rd_addr 1/3, zeta 64.
   - Cycle 783: rd_addr 4/6, zeta 65.
   - Cycle 908: rd_addr 253/255, zeta 127.
4. Full run with RAM model, Kyber zeta ROM and real butterfly: r[0]=1, others 0; then a random array → final RAM equals the software NTT model bit-exact. done=1 only in cycle 911; busy high in cycles 1–910.
5. start pulses at cycles 50 and 500 during a run → ignored; still exactly one done, at cycle 911.
6. rst asserted in cycle 300, then start → no wr_en after reset; new run's done arrives 911 cycles after the new start.
